// File: rtl/ex_div_seq.sv
// Multi-cycle RV32M divide/remainder sequencer beside EX: restoring shift-subtract,
// one quotient bit per cycle, optional single-cycle resolution of divide-by-zero/overflow.
module ex_div_seq #(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_op1,
  input  logic [XLEN-1:0] i_op2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [CW-1:0]   LAST_IT  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            done_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic            is_rem_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            div_zero_q;

  // Decode of the operation presented in IDLE.
  logic            accept;
  logic            in_signed;
  logic            in_zero;
  logic            in_ovf;
  logic            op1_neg;
  logic            op2_neg;
  logic [XLEN-1:0] op1_mag;
  logic [XLEN-1:0] op2_mag;
  logic [XLEN-1:0] special_res;

  assign accept      = (state == IDLE) && i_start && !i_flush;
  assign in_signed   = !i_funct3[0];
  assign in_zero     = (i_op2 == '0);
  assign in_ovf      = in_signed && (i_op1 == MIN_NEG) && (i_op2 == '1);
  assign op1_neg     = in_signed && i_op1[XLEN-1];
  assign op2_neg     = in_signed && i_op2[XLEN-1];
  assign op1_mag     = op1_neg ? -i_op1 : i_op1;
  assign op2_mag     = op2_neg ? -i_op2 : i_op2;
  assign special_res = i_funct3[1] ? (in_zero ? i_op1 : '0)
                                   : (in_zero ? '1 : MIN_NEG);

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative.
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [XLEN:0]   rem_next;
  logic [XLEN-1:0] quo_next;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] calc_res;

  assign shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff     = shifted - {1'b0, dvsr_q};
  assign q_bit    = !diff[XLEN];
  assign rem_next = q_bit ? diff : shifted;
  assign quo_next = {quo_q[XLEN-2:0], q_bit};

  // Divide-by-zero iterates to |op1| remainder naturally; only the quotient needs forcing.
  assign quo_fix  = div_zero_q ? '1 : (neg_quo_q ? -quo_next : quo_next);
  assign rem_fix  = neg_rem_q ? -rem_next[XLEN-1:0] : rem_next[XLEN-1:0];
  assign calc_res = is_rem_q ? rem_fix : quo_fix;

  assign o_busy = accept || (state == CALC);
  assign o_done = done_q && !i_flush;

  // NOTE: datapath registers are not reset; they are only read in CALC, which always follows a load.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      rem_q      <= '0;
      quo_q      <= op1_mag;
      dvsr_q     <= op2_mag;
      cnt_q      <= '0;
      is_rem_q   <= i_funct3[1];
      neg_quo_q  <= op1_neg ^ op2_neg;
      neg_rem_q  <= op1_neg;
      div_zero_q <= in_zero;
    end else if (state == CALC) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      o_result <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (FAST_SPECIAL && (in_zero || in_ovf)) begin
              state    <= DONE;
              done_q   <= 1'b1;
              o_result <= special_res;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (i_flush) begin
            state <= IDLE;
          end else if (cnt_q == LAST_IT) begin
            state    <= DONE;
            done_q   <= 1'b1;
            o_result <= calc_res;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // funct3[2] is always set when decode raises i_start; the remainder MSB never leaves zero.
  logic unused;
  assign unused = ^{i_funct3[2], rem_q[XLEN]};

endmodule

// File: tb/tb_ex_div_seq.sv
// Self-checking bench for ex_div_seq: directed RV32M cases, flush/reset corners and
// randomized operations compared against an arithmetic reference model.
module tb_ex_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        start_s;
  logic [2:0]  funct3;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy,   done;
  logic [31:0] result;
  logic        busy_s, done_s;
  logic [31:0] result_s;

  int errors = 0;
  int checks = 0;
  logic [31:0] last_exp;

  ex_div_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_funct3(funct3),
    .i_op1(op1), .i_op2(op2), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_result(result)
  );

  ex_div_seq #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s), .i_funct3(funct3),
    .i_op1(op1), .i_op2(op2), .i_flush(flush),
    .o_busy(busy_s), .o_done(done_s), .o_result(result_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RISC-V M semantics: truncating division, remainder follows the dividend.
  function automatic logic [31:0] ref_div(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return f[1] ? a : 32'hFFFF_FFFF;
    if (!f[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return f[1] ? r[31:0] : q[31:0];
  endfunction

  function automatic bit is_special(input logic [1:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Issue one op at the next negedge, scramble inputs afterwards, and time the done pulse.
  task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit slow, input bit pulse);
    int n, busy_low, exp_lat;
    logic [31:0] exp;
    logic ob, od;
    logic [31:0] orr;
    exp     = ref_div(f, a, b);
    exp_lat = (!slow && is_special(f, a, b)) ? 1 : 33;
    @(negedge clk);
    funct3 = {1'b1, f}; op1 = a; op2 = b;
    if (slow) start_s = 1'b1; else start = 1'b1;
    #1 ob = slow ? busy_s : busy;
    check({tag, "_busy_at_start"}, {31'd0, ob}, 32'd1);
    n = 0; busy_low = 0;
    while (n < 40) begin
      @(negedge clk);
      start = 1'b0; start_s = 1'b0;
      op1 = $urandom; op2 = $urandom; funct3 = 3'($urandom);
      n++;
      if (pulse && n == 3) begin
        funct3[2] = 1'b1;
        if (slow) start_s = 1'b1; else start = 1'b1;
      end
      #1;
      od = slow ? done_s : done;
      ob = slow ? busy_s : busy;
      if (od) break;
      if (!ob) busy_low++;
    end
    orr = slow ? result_s : result;
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, orr, exp);
    check({tag, "_busy_while_iter"}, 32'(busy_low), 32'd0);
    check({tag, "_busy_in_done"}, {31'd0, ob}, 32'd0);
    start = 1'b0; start_s = 1'b0;
    last_exp = exp;
  endtask

  initial begin
    int dones;
    logic [1:0]  f;
    logic [31:0] a, b;
    int k;

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; flush = 1'b0;
    funct3 = 3'b100; op1 = '0; op2 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_result_slow", result_s, 32'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, "remu_100_7", 1'b0, 1'b0);

    run_op(2'b00, -32'sd7, 32'd2, "div_m7_2", 1'b0, 1'b0);
    check("div_m7_2_const", last_exp, 32'hFFFF_FFFD);
    run_op(2'b10, -32'sd7, 32'd2, "rem_m7_2", 1'b0, 1'b0);
    run_op(2'b00, 32'd7, -32'sd2, "div_7_m2", 1'b0, 1'b0);
    run_op(2'b10, 32'd7, -32'sd2, "rem_7_m2", 1'b0, 1'b0);

    run_op(2'b00, 32'd5, 32'd0, "div_5_0", 1'b0, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, "remu_5_0", 1'b0, 1'b0);
    run_op(2'b10, -32'sd5, 32'd0, "rem_m5_0", 1'b0, 1'b0);
    run_op(2'b00, -32'sd5, 32'd0, "div_m5_0_slow", 1'b1, 1'b0);
    run_op(2'b00, 32'd5, 32'd0, "div_5_0_slow", 1'b1, 1'b0);
    run_op(2'b11, 32'd5, 32'd0, "remu_5_0_slow", 1'b1, 1'b0);

    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0, 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf_slow", 1'b1, 1'b0);

    // Start pulse mid-iteration must be ignored.
    run_op(2'b01, 32'd1000, 32'd9, "divu_start_pulse", 1'b0, 1'b1);

    // Flush at T+10: back to IDLE with no done, result held, then a fresh op.
    run_op(2'b01, 32'd77, 32'd5, "divu_pre_flush", 1'b0, 1'b0);
    @(negedge clk);
    funct3 = 3'b101; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (9) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_busy_t10", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_busy_t11", {31'd0, busy}, 32'd0);
    check("flush_done_t11", {31'd0, done}, 32'd0);
    check("flush_result_held", result, last_exp);
    run_op(2'b01, 32'd9, 32'd3, "divu_9_3_after_flush", 1'b0, 1'b0);

    // Flush in the DONE cycle suppresses the pulse.
    @(negedge clk);
    funct3 = 3'b101; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    repeat (32) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    flush = 1'b1;
    #1 check("flush_in_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    flush = 1'b0;

    // Flush and start together: flush wins, nothing is accepted.
    @(negedge clk);
    funct3 = 3'b101; op1 = 32'd50; op2 = 32'd5; start = 1'b1; flush = 1'b1;
    #1 check("flush_start_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    repeat (36) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      #1 if (done) dones++;
    end
    check("flush_start_no_done", 32'(dones), 32'd0);
    check("flush_start_idle", {31'd0, busy}, 32'd0);

    // Reset mid-CALC clears all outputs at the next edge.
    @(negedge clk);
    funct3 = 3'b101; op1 = 32'd500; op2 = 32'd7; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("pre_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    rst_n = 1'b1;
    run_op(2'b01, 32'd500, 32'd7, "divu_after_rst", 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      f = 2'($urandom_range(0, 3));
      a = $urandom;
      k = $urandom_range(0, 9);
      case (k)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(f, a, b, "rand", (i % 8) == 7, (i % 5) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
